// File: rtl/mips_step_ctrl_if.sv
// Button inputs and control outputs between the step controller and its user.
// The debug state fields expose both debounce FSMs for external checkers.
interface mips_step_ctrl_if;
    logic        btn_step;
    logic        btn_mode;
    logic        change;
    logic        step;
    logic        cpu_en;
    logic [15:0] step_count;
    logic [1:0]  step_state;
    logic [1:0]  mode_state;

    modport slave (
        input  btn_step, btn_mode,
        output change, step, cpu_en, step_count, step_state, mode_state
    );

    modport master (
        output btn_step, btn_mode,
        input  change, step, cpu_en, step_count, step_state, mode_state
    );
endinterface

// File: rtl/mips_step_ctrl.sv
// Run/single-step controller for a MIPS core: synchronized, debounced mode and step buttons.
// Optional STEP_CTRL_AUTOREPEAT_EN adds auto-repeat of step pulses while the step button is held.
module mips_step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_CYCLES   = 16
) (
    input  logic            clock,
    input  logic            reset,
    mips_step_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, HELD = 2'd2, DISARM = 2'd3} db_state_t;

    localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255 || REPEAT_CYCLES < 2 || REPEAT_CYCLES > 65535) begin : g_param_check
        $error("mips_step_ctrl: parameter out of range");
    end

    // Index 0 is the step button, index 1 the mode button.
    logic [1:0] raw;
    logic [1:0] sync1_q;
    logic [1:0] sync2_q;
    db_state_t  state_q [2];
    db_state_t  state_d [2];
    logic [7:0] cnt_q   [2];
    logic [7:0] cnt_d   [2];
    logic [1:0] press;

    logic        change_q;
    logic        step_q;
    logic [15:0] count_q;
    logic        rep_fire;
    logic        pulse_req;

    assign raw = {bus.btn_mode, bus.btn_step};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= 8'd0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // The press event is raised in the last ARM cycle, so outputs move on the following edge.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            press[i]   = 1'b0;
            case (state_q[i])
                IDLE: begin
                    if (sync2_q[i]) begin
                        state_d[i] = ARM;
                        cnt_d[i]   = 8'd0;
                    end
                end
                ARM: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = IDLE;
                    end else if (cnt_q[i] == DB_LAST) begin
                        state_d[i] = HELD;
                        press[i]   = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 8'd1;
                    end
                end
                HELD: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = DISARM;
                        cnt_d[i]   = 8'd0;
                    end
                end
                DISARM: begin
                    if (sync2_q[i]) begin
                        state_d[i] = HELD;
                    end else if (cnt_q[i] == DB_LAST) begin
                        state_d[i] = IDLE;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 8'd1;
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                    cnt_d[i]   = 8'd0;
                end
            endcase
        end
    end

`ifdef STEP_CTRL_AUTOREPEAT_EN
    localparam logic [15:0] RP_LAST = 16'(REPEAT_CYCLES - 1);
    logic [15:0] rep_q;

    // Fires only while the button is still seen pressed, so a release never adds a pulse.
    assign rep_fire = (state_q[0] == HELD) && sync2_q[0] && change_q && (rep_q == RP_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rep_q <= 16'd0;
        end else if (state_q[0] == HELD && change_q) begin
            rep_q <= rep_fire ? 16'd0 : rep_q + 16'd1;
        end else begin
            rep_q <= 16'd0;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    // Both events test the pre-toggle change value.
    assign pulse_req = (press[0] | rep_fire) & change_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            change_q <= 1'b0;
            step_q   <= 1'b0;
            count_q  <= 16'd0;
        end else begin
            step_q <= pulse_req;
            if (pulse_req) begin
                count_q <= count_q + 16'd1;
            end
            if (press[1]) begin
                change_q <= ~change_q;
            end
        end
    end

    assign bus.change     = change_q;
    assign bus.step       = step_q;
    assign bus.cpu_en     = change_q ? step_q : 1'b1;
    assign bus.step_count = count_q;
    assign bus.step_state = state_q[0];
    assign bus.mode_state = state_q[1];
endmodule

// File: tb/tb_mips_step_ctrl.sv
// Directed bench for mips_step_ctrl; cycle 1 is the first rising edge that samples a pressed button.
module tb_mips_step_ctrl;
    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    mips_step_ctrl_if bus ();

    mips_step_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_CYCLES  (16)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    int          pulse_q[$];
    int          cpu_q[$];
    int          cpu_low;
    logic [127:0] change_hist;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Press the selected buttons for hi cycles, observe total cycles.
    task automatic run_btn(input logic [1:0] sel, input int hi, input int total);
        pulse_q.delete();
        cpu_q.delete();
        cpu_low     = 0;
        change_hist = '0;
        bus.btn_step = sel[0];
        bus.btn_mode = sel[1];
        for (int k = 1; k <= total; k++) begin
            tick();
            if (bus.step) pulse_q.push_back(k);
            if (bus.cpu_en) cpu_q.push_back(k);
            else cpu_low++;
            change_hist[k] = bus.change;
            if (k == hi) begin
                bus.btn_step = 1'b0;
                bus.btn_mode = 1'b0;
            end
        end
    endtask

    // Compare a recorded cycle list against the expected queue, then empty it.
    task automatic check_cycles(input string tag, input int got[$]);
        int n;
        check({tag, "_count"}, got.size(), exp_q.size());
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_cycle"}, got[i], exp_q[i]);
        end
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.btn_step = 1'b0;
        bus.btn_mode = 1'b0;
        reset = 1'b0;
        #1;
        check("rst_change", bus.change, 0);
        check("rst_step", bus.step, 0);
        check("rst_count", bus.step_count, 0);
        check("rst_cpu_en", bus.cpu_en, 1);
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;

        // Mode press enters single-step mode at cycle 7.
        run_btn(2'b10, 10, 20);
        check("mode_c6", change_hist[6], 0);
        check("mode_c7", change_hist[7], 1);
        check("mode_c20", change_hist[20], 1);
        check("mode_count", bus.step_count, 0);
        check("mode_cpu_en", bus.cpu_en, 0);
        check_cycles("mode_pulses", pulse_q);

        // Held step button: one pulse at cycle 7, cpu_en high only then.
        run_btn(2'b01, 20, 30);
        exp_q.push_back(7);
        check_cycles("step_pulses", pulse_q);
        exp_q.push_back(7);
        check_cycles("step_cpu_en", cpu_q);
        check("step_count", bus.step_count, 1);

        // Glitch shorter than the debounce window.
        run_btn(2'b01, 3, 12);
        check_cycles("glitch_pulses", pulse_q);
        check("glitch_count", bus.step_count, 1);

        // Back to free run.
        run_btn(2'b10, 10, 20);
        check("run_c6", change_hist[6], 1);
        check("run_c7", change_hist[7], 0);

        // Step press in free run is ignored.
        run_btn(2'b01, 10, 20);
        check_cycles("run_step_pulses", pulse_q);
        check("run_step_count", bus.step_count, 1);
        check("run_cpu_low", cpu_low, 0);

        // Same-cycle mode and step events from free run.
        run_btn(2'b11, 10, 20);
        check("both_c7", change_hist[7], 1);
        check_cycles("both_pulses", pulse_q);
        check("both_count", bus.step_count, 1);

        // Counter wrap from 0xFFFF.
        @(negedge clock);
        force dut.count_q = 16'hFFFF;
        @(negedge clock);
        release dut.count_q;
        run_btn(2'b01, 10, 20);
        exp_q.push_back(7);
        check_cycles("wrap_pulses", pulse_q);
        check("wrap_count", bus.step_count, 0);
        check("wrap_change", bus.change, 1);

        // Reset in the middle of ARM discards the press.
        bus.btn_step = 1'b1;
        repeat (4) tick();
        reset = 1'b0;
        #1;
        check("midarm_change", bus.change, 0);
        check("midarm_step", bus.step, 0);
        check("midarm_count", bus.step_count, 0);
        check("midarm_cpu_en", bus.cpu_en, 1);
        check("midarm_state", bus.step_state, 0);
        repeat (2) tick();
        @(negedge clock);
        bus.btn_step = 1'b0;
        reset = 1'b1;
        run_btn(2'b00, 0, 12);
        check_cycles("midarm_pulses", pulse_q);
        check("midarm_count_after", bus.step_count, 0);
        check("midarm_change_after", change_hist[12], 0);

        // Mode button held across reset is a new press after release.
        bus.btn_mode = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        @(negedge clock);
        reset = 1'b1;
        run_btn(2'b10, 10, 20);
        check("held_rst_c6", change_hist[6], 0);
        check("held_rst_c7", change_hist[7], 1);

        // Long hold of the step button.
        run_btn(2'b01, 60, 70);
`ifdef STEP_CTRL_AUTOREPEAT_EN
        exp_q.push_back(7);
        exp_q.push_back(23);
        exp_q.push_back(39);
        exp_q.push_back(55);
        check_cycles("hold_pulses", pulse_q);
        check("hold_count", bus.step_count, 4);
`else
        exp_q.push_back(7);
        check_cycles("hold_pulses", pulse_q);
        check("hold_count", bus.step_count, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mips_step_ctrl.md
MIPS_STEP_CTRL -- requirements
Module: mips_step_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable synchronized cycles needed to accept a button level change (legal range 1..255).
REQ-002 Parameter REPEAT_CYCLES, default 16: auto-repeat interval in cycles (legal range 2..65535, used only under REQ-024).
REQ-003 Port clock, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-low reset.
REQ-005 Port btn_step, input, 1: raw, asynchronous step push-button (1 = pressed).
REQ-006 Port btn_mode, input, 1: raw, asynchronous mode push-button (1 = pressed).
REQ-007 Port change, output, 1: mode level to the mips core (0 = free run, 1 = single-step).
REQ-008 Port step, output, 1: single-cycle step pulse to the mips core.
REQ-009 Port cpu_en, output, 1: core advance enable (1 in run mode; equal to step in single-step mode).
REQ-010 Port step_count, output, 16: number of step pulses issued since reset.

Function
REQ-011 Each button SHALL pass through its own 2-flop synchronizer before any other logic.
REQ-012 Each button SHALL have its own debounce FSM with states IDLE, ARM, HELD, DISARM.
- IDLE: sync=1 -> ARM with counter cleared.
- ARM: counter increments while sync=1; sync=0 -> IDLE; counter reaching DEBOUNCE_CYCLES -> HELD with a one-cycle press event.
- HELD: sync=0 -> DISARM with counter cleared.
- DISARM: counter increments while sync=0; sync=1 -> HELD; counter reaching DEBOUNCE_CYCLES -> IDLE.
REQ-013 A glitch shorter than DEBOUNCE_CYCLES SHALL produce no event and no output change.
REQ-014 Latency from the first clock edge sampling a raw input high to the press event SHALL be 2+DEBOUNCE_CYCLES cycles; step and change update one cycle after the event.
REQ-015 A btn_mode press event SHALL toggle change.
REQ-016 A btn_step press event while change=1 SHALL assert step for exactly one cycle and increment step_count.
REQ-017 A btn_step press event while change=0 SHALL be ignored: no pulse, no count.
REQ-018 Events in the same cycle on both buttons SHALL be evaluated against the pre-toggle value of change.
REQ-019 A held button SHALL produce exactly one event until it is debounced released.
REQ-020 step_count SHALL wrap from 0xFFFF to 0x0000 without any other effect.
REQ-021 cpu_en SHALL be combinational: change ? step : 1.

Reset
REQ-022 On reset=0, asynchronously: change=0, step=0, step_count=0, synchronizers=0, both FSMs in IDLE, counters cleared, so cpu_en=1.
REQ-023 A button still held when reset releases SHALL be recognized as a new press after 2+DEBOUNCE_CYCLES cycles; reset asserted mid-debounce discards the partial count.

Configuration
REQ-024 With STEP_CTRL_AUTOREPEAT_EN defined, while the step FSM stays in HELD and change=1, a further step pulse SHALL be issued every REPEAT_CYCLES cycles after the initial pulse, each counted in step_count. The repeat timer clears on leaving HELD or on change=0.
REQ-025 Without STEP_CTRL_AUTOREPEAT_EN, the repeat timer SHALL not exist and a held button yields exactly one pulse.

Verification
REQ-026 Reset released, btn_mode high 10 cycles then low 10 -> change=1 from cycle 7; step_count=0; cpu_en=0.
REQ-027 change=1, btn_step high 20 cycles -> exactly one step pulse at cycle 7, step_count=1, cpu_en=1 only in that cycle (macro undefined).
REQ-028 change=1, btn_step high 3 cycles then low -> no pulse, step_count unchanged.
REQ-029 change=0, btn_step press -> no pulse, step_count=0, cpu_en stays 1; same-cycle mode+step events from change=0 -> change=1, no step.
REQ-030 Preload 0xFFFF steps, one more press -> step_count=0x0000; reset pulsed mid-ARM -> all outputs at reset values, no event.
REQ-031 Macro defined, REPEAT_CYCLES=16, change=1, btn_step held 60 cycles -> pulses at cycles 7, 23, 39, 55; step_count=4.
